// File: rtl/delay_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delay_pkg                                                  |
// | Description : Shared constants, address-width helper and responder       |
// |               state encodings for the delay-line memory responder.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package delay_pkg;

  localparam int DELAY_DATA_WIDTH = 16;
  localparam int DELAY_MEM_SIZE   = 8192;

  // Address width for a RAM of the given depth (at least one bit).
  function automatic int delay_addr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Responder states; CLEAR is only reachable when the clear sweep is built in.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ_PIPE = 3'd1,
    ST_HOLDOFF_W = 3'd2,
    ST_HOLDOFF_R = 3'd3,
    ST_CLEAR     = 3'd4
  } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/delay_sample_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delay_sample_ram                                           |
// | Description : Single-port synchronous sample RAM with READ_LATENCY-1     |
// |               extra output stages and a matching valid/error chain.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module delay_sample_ram
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH   = DELAY_DATA_WIDTH,
  parameter int MEMORY_SIZE  = DELAY_MEM_SIZE,
  parameter int ADDR_WIDTH   = 13,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rerr
);

  logic [DATA_WIDTH-1:0]   r_mem [MEMORY_SIZE];
  logic [DATA_WIDTH-1:0]   r_data_pipe [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_valid_pipe;
  logic [READ_LATENCY-1:0] r_err_pipe;

  // RAM write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read data: stage 0 loads only on a read so the last sample is held;
  // out-of-range reads load zero instead of touching the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_data_pipe[k] <= '0;
      end
    end else begin
      if (rd_en) begin
        r_data_pipe[0] <= rd_zero ? '0 : r_mem[addr];
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_data_pipe[k] <= r_data_pipe[k-1];
      end
    end
  end

  // Valid and address-error tags travel alongside the data stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_pipe <= '0;
      r_err_pipe   <= '0;
    end else begin
      r_valid_pipe[0] <= rd_en;
      r_err_pipe[0]   <= rd_en & rd_zero;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_valid_pipe[k] <= r_valid_pipe[k-1];
        r_err_pipe[k]   <= r_err_pipe[k-1];
      end
    end
  end

  assign rdata  = r_data_pipe[READ_LATENCY-1];
  assign rvalid = r_valid_pipe[READ_LATENCY-1];
  assign rerr   = r_err_pipe[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/delay_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delay_mem_responder                                        |
// | Description : Memory-side responder for level-held read/write requests.  |
// |               One access per cycle on a shared single-port RAM; each     |
// |               held request produces exactly one completion pulse.        |
// |               Optional macro MEM_CLEAR_EN: zero the RAM after reset.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module delay_mem_responder
  import delay_pkg::*;
#(
  parameter  int DATA_WIDTH   = DELAY_DATA_WIDTH,
  parameter  int MEMORY_SIZE  = DELAY_MEM_SIZE,
  parameter  int READ_LATENCY = 2,
  localparam int ADDR_WIDTH   = delay_addr_width(MEMORY_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_req,
  input  logic                         write_req,
  input  logic        [ADDR_WIDTH-1:0] read_addr,
  input  logic        [ADDR_WIDTH-1:0] write_addr,
  input  logic signed [DATA_WIDTH-1:0] write_data,
  output logic signed [DATA_WIDTH-1:0] read_data,
  output logic                         read_valid,
  output logic                         write_ack,
  output logic                         addr_error,
  output logic                         ready
);

  localparam logic [ADDR_WIDTH:0] c_mem_size  = (ADDR_WIDTH+1)'(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH:0] c_last_addr = (ADDR_WIDTH+1)'(MEMORY_SIZE - 1);
  // READ_PIPE spans READ_LATENCY-1 cycles; counter runs 0..READ_LATENCY-2.
  localparam logic [1:0] c_pipe_last = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  resp_state_t            r_state, w_state_next;
  logic [1:0]             r_pipe_cnt, w_pipe_cnt_next;
  logic                   r_write_ack, r_wr_err;
  logic                   w_ack_next, w_wr_err_next;
  logic                   w_wr_oob, w_rd_oob;
  logic                   w_ram_wr_en, w_ram_rd_en, w_ram_rd_zero;
  logic [ADDR_WIDTH-1:0]  w_ram_addr;
  logic [DATA_WIDTH-1:0]  w_ram_wdata;
  logic                   w_rd_err;
`ifdef MEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0]  r_clr_addr, w_clr_addr_next;
`endif

  assign w_wr_oob = ({1'b0, write_addr} >= c_mem_size);
  assign w_rd_oob = ({1'b0, read_addr} >= c_mem_size);

  // State, pipeline counter and clear pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef MEM_CLEAR_EN
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
`else
      r_state    <= ST_IDLE;
`endif
      r_pipe_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_pipe_cnt <= w_pipe_cnt_next;
`ifdef MEM_CLEAR_EN
      r_clr_addr <= w_clr_addr_next;
`endif
    end
  end

  // Next-state logic and RAM port arbitration; writes win over reads in IDLE.
  always_comb begin
    w_state_next    = r_state;
    w_pipe_cnt_next = r_pipe_cnt;
    w_ram_wr_en     = 1'b0;
    w_ram_rd_en     = 1'b0;
    w_ram_rd_zero   = 1'b0;
    w_ram_addr      = read_addr;
    w_ram_wdata     = write_data;
    w_ack_next      = 1'b0;
    w_wr_err_next   = 1'b0;
`ifdef MEM_CLEAR_EN
    w_clr_addr_next = r_clr_addr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (write_req) begin
          w_ram_wr_en   = ~w_wr_oob;
          w_ram_addr    = write_addr;
          w_ack_next    = 1'b1;
          w_wr_err_next = w_wr_oob;
          w_state_next  = ST_HOLDOFF_W;
        end else if (read_req) begin
          w_ram_rd_en     = 1'b1;
          w_ram_rd_zero   = w_rd_oob;
          w_pipe_cnt_next = 2'd0;
          w_state_next    = (READ_LATENCY > 1) ? ST_READ_PIPE : ST_HOLDOFF_R;
        end
      end
      ST_READ_PIPE: begin
        if (r_pipe_cnt == c_pipe_last) begin
          w_state_next = ST_HOLDOFF_R;
        end else begin
          w_pipe_cnt_next = r_pipe_cnt + 2'd1;
        end
      end
      ST_HOLDOFF_W: begin
        if (!write_req) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_HOLDOFF_R: begin
        if (!read_req) begin
          w_state_next = ST_IDLE;
        end
      end
`ifdef MEM_CLEAR_EN
      ST_CLEAR: begin
        w_ram_wr_en = 1'b1;
        w_ram_addr  = r_clr_addr;
        w_ram_wdata = '0;
        if ({1'b0, r_clr_addr} == c_last_addr) begin
          w_state_next = ST_IDLE;
        end else begin
          w_clr_addr_next = r_clr_addr + 1'b1;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Write completion pulse and its address-error flag, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_ack <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_write_ack <= w_ack_next;
      r_wr_err    <= w_wr_err_next;
    end
  end

  delay_sample_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_SIZE  (MEMORY_SIZE),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_ram_wr_en),
    .rd_en   (w_ram_rd_en),
    .rd_zero (w_ram_rd_zero),
    .addr    (w_ram_addr),
    .wdata   (w_ram_wdata),
    .rdata   (read_data),
    .rvalid  (read_valid),
    .rerr    (w_rd_err)
  );

  assign write_ack  = r_write_ack;
  assign addr_error = r_wr_err | w_rd_err;
  assign ready      = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: doc/delay_mem_responder.md
Name: delay_mem_responder

Overview:
- Memory-side responder for the delay-line engine's level-held read/write request interface.
- Serves one initiator, the delay buffer manager, against an on-chip sample RAM of memory_size words.
- Produces a one-cycle write_ack per accepted write and a one-cycle read_valid per accepted read.
- Enforces a hold-off so each held request is serviced exactly once.

Parameters:
data_width, 16, sample word width
memory_size, 8192, RAM depth in words; need not be a power of two
READ_LATENCY, 2, cycles from read acceptance to read_valid (1..4)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
read_req  input  1  read request, held high by initiator until read_valid seen
write_req  input  1  write request, held high until write_ack seen
read_addr  input  addr_width  read word address; addr_width = $clog2(memory_size)
write_addr  input  addr_width  write word address
write_data  input  data_width  signed write sample
read_data  output  data_width  signed read sample, valid with read_valid
read_valid  output  1  one-cycle read completion pulse
write_ack  output  1  one-cycle write completion pulse
addr_error  output  1  one-cycle pulse: serviced address >= memory_size
ready  output  1  high when in IDLE (accepting requests)

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous and active-high.
- Reset values: read_data=0, read_valid=0, write_ack=0, addr_error=0; ready=1, or 0 if a clear sweep is starting.
- On reset: in-flight read is discarded, no pulse issued; RAM contents retained unless MEM_CLEAR_EN.
- States: IDLE, READ_PIPE, HOLDOFF_W, HOLDOFF_R, CLEAR (CLEAR only with MEM_CLEAR_EN).
- IDLE, write_req=1 in cycle N:
  - RAM[write_addr] <= write_data at the edge ending cycle N.
  - write_ack=1 in cycle N+1 -> HOLDOFF_W.
- IDLE, read_req=1 and write_req=0 in cycle N:
  - Address latched; read_data/read_valid presented in cycle N+READ_LATENCY -> HOLDOFF_R.
  - READ_PIPE counts READ_LATENCY-1 cycles.
- Simultaneous read_req and write_req: write wins.
  - Read is serviced after HOLDOFF_W if still held.
  - Same address: read returns the newly written data.
- HOLDOFF_W: stay while write_req=1; -> IDLE in the first cycle write_req=0. HOLDOFF_R: same, on read_req.
- Initiator drops req one cycle after the pulse, so hold-off lasts >=1 cycle; throughput is one transaction per 3 cycles (write) or READ_LATENCY+2 (read).
- Pulses never repeat for a single held request; a request raised during hold-off of the other type waits in IDLE.
- Requests are ignored unless in IDLE (the ready signal is high only in IDLE).
- Address >= memory_size:
  - Write: RAM untouched, write_ack still issued, addr_error pulses with it.
  - Read: read_data=0 with read_valid, addr_error pulses with it.
- read_data holds its last value between pulses.
- RAM is a single inferred synchronous array, one port shared by read and write (one access per cycle).

Optional Feature:
- Macro MEM_CLEAR_EN.
- Defined:
  - After reset deassertion, enter CLEAR with ready=0.
  - Write 0 to addresses 0..memory_size-1, one per cycle (memory_size cycles), then -> IDLE.
  - Requests arriving during CLEAR stay pending and are serviced afterwards.
  - Reset during CLEAR restarts the sweep at 0.
- Undefined: no CLEAR state; ready=1 from the first cycle after reset; RAM power-up content undefined.

Decomposition:
- Shared package delay_pkg:
  - DELAY_DATA_WIDTH=16, DELAY_MEM_SIZE=8192, DELAY_ADDR_WIDTH function/constant.
  - Responder state encodings.
- One sub-module, delay_sample_ram: single-port synchronous RAM plus READ_LATENCY-1 output register stages, with a valid shift chain alongside.

Test Plan:
- Write-back-to-back: write_req addr 5 data 0x1234, drop req on ack -> write_ack exactly 1 cycle, in N+1. Read addr 5 -> read_data 0x1234, read_valid at N+2 (READ_LATENCY=2), single pulse.
- Held request: keep write_req high 6 cycles after ack -> exactly one write_ack. Then drop, raise read_req -> single read_valid.
- Simultaneous read/write, both addr 100, write data 0xBEEF -> write_ack first, then read_valid with 0xBEEF.
- memory_size=6000, write addr 6001 -> write_ack + addr_error, RAM[6001 mod] unchanged. Read addr 7000 -> read_data 0, addr_error.
- Reset asserted the cycle after read acceptance -> no read_valid ever. All outputs 0 next cycle; subsequent read of prior-written addr returns old data (clear disabled).
- MEM_CLEAR_EN, memory_size=64: preload addr 10 = 0x7FFF, reset -> ready low exactly 64 cycles. Read addr 10 afterwards -> 0x0000.
